vita_packet_mux36: RTL and testbench

- Packet-granular round-robin arbiter that shares one 36-bit VITA output stream among NUMCHAN 36-bit input streams.
- It is the transmit-side counterpart of the SID demux. On each packet it inserts a stream ID word of SID_BASE + channel after the header, sets the header has_sid bit (28) and adds one to the header length field [15:0].
- It sits between the per-channel framers and the shared link or FIFO toward the host.

---
 rtl/vita_packet_mux36_pkg.sv | 35 +++
 rtl/vita_packet_mux36_if.sv | 22 ++
 rtl/vita_packet_mux36_rr_arbiter.sv | 50 +++++
 rtl/vita_packet_mux36.sv | 144 ++++++++++++++
 tb/tb_vita_packet_mux36.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/vita_packet_mux36_pkg.sv
// Shared VITA-36 definitions: bit positions of the 36-bit stream word,
// the mux FSM state encoding and the header rewrite helper.
package vita36_pkg;

    localparam int SOF_BIT     = 32;
    localparam int EOF_BIT     = 33;
    localparam int OCC_HI      = 35;
    localparam int OCC_LO      = 34;
    localparam int HAS_SID_BIT = 28;
    localparam int LEN_HI      = 15;
    localparam int LEN_LO      = 0;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE_HDR = 2'd1,
        WRITE_SID = 2'd2,
        FORWARD   = 2'd3
    } state_t;

    // A header without a SID gets has_sid set, its length bumped for the
    // inserted word, occupancy cleared and EOF removed (EOF moves to the
    // SID word). A header that already carries a SID passes untouched.
    function automatic logic [35:0] rewrite_hdr(input logic [35:0] hdr);
        logic [35:0] r;
        r = hdr;
        if (!hdr[HAS_SID_BIT]) begin
            r[OCC_HI:OCC_LO]  = 2'b00;
            r[EOF_BIT]        = 1'b0;
            r[HAS_SID_BIT]    = 1'b1;
            r[LEN_HI:LEN_LO]  = hdr[LEN_HI:LEN_LO] + 16'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/vita_packet_mux36_if.sv
// Stream bundle between the per-channel framers, the packet mux and the
// shared output link. The mux itself uses the slave view.
interface vita_packet_mux36_if #(
    parameter int NUMCHAN = 2
);
    logic [NUMCHAN*36-1:0] in_data;
    logic [NUMCHAN-1:0]    in_src_rdy;
    logic [NUMCHAN-1:0]    in_dst_rdy;
    logic [35:0]           out_data;
    logic                  out_src_rdy;
    logic                  out_dst_rdy;

    modport slave (
        input  in_data, in_src_rdy, out_dst_rdy,
        output in_dst_rdy, out_data, out_src_rdy
    );

    modport master (
        output in_data, in_src_rdy, out_dst_rdy,
        input  in_dst_rdy, out_data, out_src_rdy
    );
endinterface

// File: rtl/vita_packet_mux36_rr_arbiter.sv
// Round-robin arbiter: combinational search from the pointer upward with
// wrap-around; the pointer moves past the finished channel on advance.
module rr_arbiter
    import vita36_pkg::*;
#(
    parameter int NUMCHAN = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUMCHAN-1:0] req,
    input  logic               advance,
    input  logic [3:0]         last_chan,
    output logic [3:0]         grant,
    output logic               grant_vld
);

    localparam logic [3:0] LAST_IDX = 4'(NUMCHAN - 1);

    logic [3:0] ptr_q;
    logic       found;

    // Pointer register: next search starts just after the channel that finished.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 4'd0;
        end else if (advance) begin
            ptr_q <= (last_chan == LAST_IDX) ? 4'd0 : last_chan + 4'd1;
        end
    end

    // First pass covers ptr..NUMCHAN-1, second pass wraps to 0..ptr-1.
    always_comb begin
        grant = 4'd0;
        found = 1'b0;
        for (int i = 0; i < NUMCHAN; i++) begin
            if (!found && req[i] && (i[3:0] >= ptr_q)) begin
                grant = i[3:0];
                found = 1'b1;
            end
        end
        for (int i = 0; i < NUMCHAN; i++) begin
            if (!found && req[i]) begin
                grant = i[3:0];
                found = 1'b1;
            end
        end
        grant_vld = found;
    end

endmodule

// File: rtl/vita_packet_mux36.sv
// Packet-granular round-robin mux of NUMCHAN VITA-36 streams onto one link,
// inserting a SID word (SID_BASE + channel) after each header lacking one.
module vita_packet_mux36
    import vita36_pkg::*;
#(
    parameter int          NUMCHAN  = 2,
    parameter logic [31:0] SID_BASE = 32'h0
) (
    input  logic                clk,
    input  logic                rst,
    vita_packet_mux36_if.slave  bus,
    input  logic [NUMCHAN-1:0]  chan_enable,
    output logic [3:0]          active_chan
);

    state_t             state_q, state_d;
    logic [3:0]         chan_q, chan_d;
    logic               sid_eof_q, sid_eof_d;
    logic [35:0]        sel_word;
    logic               sel_vld;
    logic [NUMCHAN-1:0] sel_mask;
    logic [NUMCHAN-1:0] sof_vec;
    logic [NUMCHAN-1:0] drain_vec;
    logic               drain_found;
    logic [NUMCHAN-1:0] req;
    logic [3:0]         grant;
    logic               grant_vld;
    logic               advance;
    logic               out_hs;
    logic [31:0]        sid_word;

    assign req         = chan_enable & bus.in_src_rdy & sof_vec;
    assign out_hs      = sel_vld & bus.out_dst_rdy;
    assign sid_word    = SID_BASE + {28'd0, chan_q};
    assign active_chan = chan_q;

    rr_arbiter #(
        .NUMCHAN (NUMCHAN)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .advance   (advance),
        .last_chan (chan_q),
        .grant     (grant),
        .grant_vld (grant_vld)
    );

    // Channel select, SOF vector and lowest-index non-SOF drain candidate.
    always_comb begin
        sel_word    = '0;
        sel_vld     = 1'b0;
        sel_mask    = '0;
        sof_vec     = '0;
        drain_vec   = '0;
        drain_found = 1'b0;
        for (int i = 0; i < NUMCHAN; i++) begin
            sof_vec[i] = bus.in_data[36*i + SOF_BIT];
            if (chan_q == i[3:0]) begin
                sel_mask[i] = 1'b1;
                sel_word    = bus.in_data[36*i +: 36];
                sel_vld     = bus.in_src_rdy[i];
            end
            if (!drain_found && chan_enable[i] && bus.in_src_rdy[i] &&
                !bus.in_data[36*i + SOF_BIT]) begin
                drain_vec[i] = 1'b1;
                drain_found  = 1'b1;
            end
        end
    end

    // FSM next state and stream outputs; nothing is registered on the data path.
    always_comb begin
        state_d         = state_q;
        chan_d          = chan_q;
        sid_eof_d       = sid_eof_q;
        advance         = 1'b0;
        bus.out_data    = '0;
        bus.out_src_rdy = 1'b0;
        bus.in_dst_rdy  = '0;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    state_d = WRITE_HDR;
                    chan_d  = grant;
                end else begin
                    bus.in_dst_rdy = drain_vec;
                end
            end
            WRITE_HDR: begin
                bus.out_data    = rewrite_hdr(sel_word);
                bus.out_src_rdy = sel_vld;
                bus.in_dst_rdy  = sel_mask & {NUMCHAN{bus.out_dst_rdy}};
                if (out_hs) begin
                    if (!sel_word[HAS_SID_BIT]) begin
                        state_d   = WRITE_SID;
                        sid_eof_d = sel_word[EOF_BIT];
                    end else if (sel_word[EOF_BIT]) begin
                        state_d = IDLE;
                        advance = 1'b1;
                    end else begin
                        state_d = FORWARD;
                    end
                end
            end
            WRITE_SID: begin
                bus.out_data    = {2'b00, sid_eof_q, 1'b0, sid_word};
                bus.out_src_rdy = 1'b1;
                if (bus.out_dst_rdy) begin
                    if (sid_eof_q) begin
                        state_d = IDLE;
                        advance = 1'b1;
                    end else begin
                        state_d = FORWARD;
                    end
                end
            end
            FORWARD: begin
                bus.out_data    = sel_word;
                bus.out_src_rdy = sel_vld;
                bus.in_dst_rdy  = sel_mask & {NUMCHAN{bus.out_dst_rdy}};
                if (out_hs && sel_word[EOF_BIT]) begin
                    state_d = IDLE;
                    advance = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, granted channel and pending SID-carries-EOF flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            chan_q    <= 4'd0;
            sid_eof_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            chan_q    <= chan_d;
            sid_eof_q <= sid_eof_d;
        end
    end

endmodule

// File: tb/tb_vita_packet_mux36.sv
// Bench for vita_packet_mux36: cycle table for directed scenarios, a short
// reset-in-packet sequence, then random packets under random backpressure
// checked against a packet-level reference stream.
module tb_vita_packet_mux36;

    localparam int          NCH  = 2;
    localparam logic [31:0] SIDB = 32'h0000_0100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] chan_enable;
    logic [3:0] active_chan;

    vita_packet_mux36_if #(.NUMCHAN(NCH)) bus();

    vita_packet_mux36 #(
        .NUMCHAN  (NCH),
        .SID_BASE (SIDB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .chan_enable (chan_enable),
        .active_chan (active_chan)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic [1:0]  en;
        logic [1:0]  src;
        logic [35:0] d0;
        logic [35:0] d1;
        logic        e_src;
        logic [1:0]  e_dst;
        logic [3:0]  e_act;
        logic [35:0] e_data;
    } vec_t;

    vec_t        vecs[$];
    int          npass  = 0;
    int          ntotal = 0;

    logic [35:0] q0[$];
    logic [35:0] q1[$];
    logic [35:0] exp_q[$];
    int          expch_q[$];

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic add(input logic r, input logic [1:0] en, input logic [1:0] src,
                       input logic [35:0] d0, input logic [35:0] d1, input logic es,
                       input logic [1:0] ed, input logic [3:0] ea, input logic [35:0] edat);
        vec_t v;
        v = '{r, en, src, d0, d1, es, ed, ea, edat};
        vecs.push_back(v);
    endtask

    // Build one packet for channel ch and append the words the link must carry.
    task automatic gen_pkt(input int ch, input int len, input bit has_sid);
        logic [35:0] hdr;
        logic [35:0] w;
        logic [15:0] l;
        hdr        = {2'($urandom_range(0, 3)), (len == 1), 1'b1, 32'($urandom)};
        hdr[28]    = has_sid;
        l          = 16'($urandom_range(0, 16'hFFFE));
        hdr[15:0]  = l;
        if (ch == 0) q0.push_back(hdr); else q1.push_back(hdr);
        if (has_sid) begin
            exp_q.push_back(hdr);
            expch_q.push_back(ch);
        end else begin
            exp_q.push_back({2'b00, 1'b0, 1'b1, hdr[31:29], 1'b1, hdr[27:16], l + 16'd1});
            expch_q.push_back(ch);
            exp_q.push_back({2'b00, (len == 1), 1'b0, SIDB + 32'(ch)});
            expch_q.push_back(ch);
        end
        for (int k = 1; k < len; k++) begin
            w = {2'($urandom_range(0, 3)), (k == len - 1), 1'b0, 32'($urandom)};
            if (ch == 0) q0.push_back(w); else q1.push_back(w);
            exp_q.push_back(w);
            expch_q.push_back(ch);
        end
    endtask

    initial begin
        vec_t        v;
        logic [35:0] held;
        logic [35:0] w;
        bit          hold_pend;
        bit          take0, take1;
        int          cyc, nw, extra;

        chan_enable     = 2'b11;
        bus.in_data     = '0;
        bus.in_src_rdy  = 2'b00;
        bus.out_dst_rdy = 1'b1;

        // rst, en, src, d0, d1 | exp src, in_dst_rdy, active_chan, out_data
        add(0, 2'b11, 2'b10, 36'h0,            36'h1_0000_0003, 0, 2'b00, 0, 36'h0);
        add(0, 2'b11, 2'b10, 36'h0,            36'h1_0000_0003, 1, 2'b10, 1, 36'h1_1000_0004);
        add(0, 2'b11, 2'b10, 36'h0,            36'h0_AAAA_0001, 1, 2'b00, 1, 36'h0_0000_0101);
        add(0, 2'b11, 2'b10, 36'h0,            36'h0_AAAA_0001, 1, 2'b10, 1, 36'h0_AAAA_0001);
        add(0, 2'b11, 2'b10, 36'h0,            36'h2_BBBB_0002, 1, 2'b10, 1, 36'h2_BBBB_0002);
        add(0, 2'b11, 2'b00, 36'h0,            36'h0,           0, 2'b00, 1, 36'h0);
        add(0, 2'b11, 2'b01, 36'h3_0000_0001,  36'h0,           0, 2'b00, 1, 36'h0);
        add(0, 2'b11, 2'b01, 36'h3_0000_0001,  36'h0,           1, 2'b01, 0, 36'h1_1000_0002);
        add(0, 2'b11, 2'b00, 36'h0,            36'h0,           1, 2'b00, 0, 36'h2_0000_0100);
        add(0, 2'b11, 2'b11, 36'h1_0000_0001,  36'h1_0000_0002, 0, 2'b00, 0, 36'h0);
        add(0, 2'b11, 2'b11, 36'h1_0000_0001,  36'h1_0000_0002, 1, 2'b10, 1, 36'h1_1000_0003);
        add(0, 2'b11, 2'b11, 36'h1_0000_0001,  36'h0_1234_5678, 1, 2'b00, 1, 36'h0_0000_0101);
        add(0, 2'b11, 2'b11, 36'h1_0000_0001,  36'h0_1234_5678, 1, 2'b10, 1, 36'h0_1234_5678);
        add(1, 2'b11, 2'b11, 36'h1_0000_0001,  36'h0_1234_5678, 1, 2'b10, 1, 36'h0_1234_5678);
        add(0, 2'b11, 2'b11, 36'h1_0000_0001,  36'h1_0000_0002, 0, 2'b00, 0, 36'h0);
        add(0, 2'b11, 2'b11, 36'h1_0000_0001,  36'h1_0000_0002, 1, 2'b01, 0, 36'h1_1000_0002);
        add(0, 2'b11, 2'b01, 36'h2_0000_0077,  36'h0,           1, 2'b00, 0, 36'h0_0000_0100);
        add(0, 2'b11, 2'b01, 36'h2_0000_0077,  36'h0,           1, 2'b01, 0, 36'h2_0000_0077);
        add(0, 2'b11, 2'b11, 36'h0_DEAD_0001,  36'h0_BEEF_0002, 0, 2'b01, 0, 36'h0);
        add(0, 2'b11, 2'b10, 36'h0,            36'h0_BEEF_0002, 0, 2'b10, 0, 36'h0);
        add(0, 2'b11, 2'b00, 36'h0,            36'h0,           0, 2'b00, 0, 36'h0);
        add(0, 2'b10, 2'b01, 36'h1_1000_0005,  36'h0,           0, 2'b00, 0, 36'h0);
        add(0, 2'b10, 2'b01, 36'h1_1000_0005,  36'h0,           0, 2'b00, 0, 36'h0);
        add(0, 2'b11, 2'b01, 36'h1_1000_0005,  36'h0,           0, 2'b00, 0, 36'h0);
        add(0, 2'b00, 2'b01, 36'h1_1000_0005,  36'h0,           1, 2'b01, 0, 36'h1_1000_0005);
        add(0, 2'b00, 2'b01, 36'h2_0000_00AA,  36'h0,           1, 2'b01, 0, 36'h2_0000_00AA);
        add(0, 2'b11, 2'b00, 36'h0,            36'h0,           0, 2'b00, 0, 36'h0);

        repeat (2) @(posedge clk);
        #1;

        // Directed cycle table
        foreach (vecs[i]) begin
            v               = vecs[i];
            rst             = v.rst;
            chan_enable     = v.en;
            bus.in_src_rdy  = v.src;
            bus.in_data     = {v.d1, v.d0};
            bus.out_dst_rdy = 1'b1;
            @(negedge clk);
            chk($sformatf("row%0d_vld", i), 36'(bus.out_src_rdy), 36'(v.e_src));
            chk($sformatf("row%0d_dst", i), 36'(bus.in_dst_rdy), 36'(v.e_dst));
            chk($sformatf("row%0d_act", i), 36'(active_chan), 36'(v.e_act));
            if (v.e_src) chk($sformatf("row%0d_data", i), bus.out_data, v.e_data);
            @(posedge clk);
            #1;
        end

        // Reset while a header is stalled by backpressure
        chan_enable     = 2'b11;
        bus.in_data     = {36'h1_0000_0004, 36'h0};
        bus.in_src_rdy  = 2'b10;
        bus.out_dst_rdy = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("stall_vld", 36'(bus.out_src_rdy), 36'h1);
        chk("stall_data", bus.out_data, 36'h1_1000_0005);
        chk("stall_act", 36'(active_chan), 36'h1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_vld", 36'(bus.out_src_rdy), 36'h0);
        chk("rst_dst", 36'(bus.in_dst_rdy), 36'h0);
        chk("rst_act", 36'(active_chan), 36'h0);
        bus.in_src_rdy = 2'b00;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Random packets, both channels always offering, random backpressure
        for (int p = 0; p < 10; p++) begin
            gen_pkt(0, (p == 0) ? 10 : $urandom_range(1, 6), ($urandom_range(0, 3) == 0));
            gen_pkt(1, $urandom_range(1, 6), ($urandom_range(0, 3) == 0));
        end
        hold_pend = 1'b0;
        held      = '0;
        cyc       = 0;
        nw        = 0;
        while (exp_q.size() > 0 && cyc < 4000) begin
            cyc++;
            bus.in_data[35:0]  = (q0.size() > 0) ? q0[0] : 36'h0;
            bus.in_data[71:36] = (q1.size() > 0) ? q1[0] : 36'h0;
            bus.in_src_rdy     = {q1.size() > 0, q0.size() > 0};
            bus.out_dst_rdy    = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (hold_pend) begin
                chk("hold_vld", 36'(bus.out_src_rdy), 36'h1);
                chk("hold_data", bus.out_data, held);
            end
            chk("dst_onehot", 36'($countones(bus.in_dst_rdy) <= 1), 36'h1);
            hold_pend = bus.out_src_rdy && !bus.out_dst_rdy;
            held      = bus.out_data;
            if (bus.out_src_rdy && bus.out_dst_rdy) begin
                w = exp_q.pop_front();
                chk($sformatf("word%0d", nw), bus.out_data, w);
                chk($sformatf("word%0d_chan", nw), 36'(active_chan), 36'(expch_q.pop_front()));
                nw++;
            end
            take0 = bus.in_dst_rdy[0] && bus.in_src_rdy[0];
            take1 = bus.in_dst_rdy[1] && bus.in_src_rdy[1];
            @(posedge clk);
            #1;
            if (take0 && q0.size() > 0) void'(q0.pop_front());
            if (take1 && q1.size() > 0) void'(q1.pop_front());
        end
        chk("stream_left", 36'(exp_q.size()), 36'h0);
        chk("src0_left", 36'(q0.size()), 36'h0);
        chk("src1_left", 36'(q1.size()), 36'h0);

        extra = 0;
        bus.in_src_rdy  = 2'b00;
        bus.out_dst_rdy = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (bus.out_src_rdy) extra++;
        end
        chk("no_extra_words", 36'(extra), 36'h0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
